csr_commit_sched: RTL and testbench
===================================

Name: csr_commit_sched

Overview:
- Sequences writeback-stage CSR commit events onto the single-port CSR difftest sync interface.
- One retiring instruction can carry both a CSR write and an exception/trap record. The block splits such a beat into at most two ordered events.
- Events are buffered in a small FIFO and issued one per cycle with a valid/ready handshake.
- Sits between the WB stage and the DPI CSR commit wrapper. It also provides an idle flag so the sim harness can drain commits before finishing.

Parameters:
- DEPTH, 4, FIFO entries in events. Power of two, ≥2.
- CW, 32, counter width of commit_cnt.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 clears state at posedge).
- in_valid  in  1  WB beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_csr_wen  in  1  beat carries a CSR write.
- in_csr_waddr  in  32  CSR address.
- in_csr_wdata  in  32  CSR write data.
- in_exc_wen  in  1  beat carries an exception/trap.
- in_mcause  in  32  exception cause.
- in_pc  in  32  pc of the excepting instruction.
- out_valid  out  1  head event valid.
- out_ready  in  1  consumer accepts head event.
- out_kind  out  1  0 = CSR write, 1 = exception.
- out_data0  out  32  waddr (kind 0) or mcause (kind 1).
- out_data1  out  32  wdata (kind 0) or pc (kind 1).
- commit_cnt  out  CW  events issued since reset; wraps modulo 2^CW.
- idle  out  1  FIFO empty and in_valid==0.

Behaviour:
- Reset (reset==0 at posedge):
  - Read/write pointers and count go to 0; commit_cnt goes to 0.
  - All buffered events are discarded, including when reset arrives mid-drain.
  - During reset, out_valid=0 and in_ready=0.
- Storage: FIFO of {kind, data0, data1}, 65 bits per entry. Count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- in_ready = (count ≤ DEPTH-2), from registered state only. It does not depend on this cycle's pop.
- Accept: a beat is accepted when in_valid && in_ready. If in_ready==0, the beat is ignored and WB must hold it.
- Push order within an accepted beat:
  - in_csr_wen=1 pushes the CSR event at wptr.
  - in_exc_wen=1 then pushes the exception event at the next slot (wptr+1 if a CSR event was also pushed, else wptr).
  - A beat with both wen bits 0 is accepted and pushes nothing.
- Pop:
  - out_valid = (count != 0). out_kind/data0/data1 are driven combinationally from the head entry.
  - A pop occurs when out_valid && out_ready. rptr advances by 1 and commit_cnt increments by 1.
- Count update: count_next = count + pushes − pop, where pushes ∈ {0,1,2} and pop ∈ {0,1}.
  - Simultaneous push and pop in the same cycle is legal.
  - Count never exceeds DEPTH, guaranteed by the in_ready rule.
- Latency: an event accepted at edge N appears on out_* in the cycle after edge N. There is no bypass from input to output.
- Ordering: strict FIFO. Within a beat, the CSR write always precedes the exception.
- Output stability: while out_valid && !out_ready, out_* stay stable until the pop.
- Empty: out_valid=0. out_data* hold the stale head contents, which are don't-care.
- idle = (count==0) && !in_valid, computed combinationally.
- No state machine beyond the FIFO. Sequencing of dual-event beats is carried entirely by FIFO order.

Test Plan:
- Single CSR write: beat {csr_wen=1, waddr=0x300, wdata=0x1800}, out_ready=1.
  - Next cycle: out_valid=1, kind=0, data0=0x300, data1=0x1800.
  - Following cycle: out_valid=0, commit_cnt=1, idle=1.
- Dual event: beat {csr_wen=1, waddr=0x341, wdata=0x80000010, exc_wen=1, mcause=11, pc=0x80000010}.
  - Output sequence is kind0 (0x341, 0x80000010), then kind1 (11, 0x80000010) on consecutive cycles.
  - commit_cnt ends at 2.
- Backpressure/full (DEPTH=4): hold out_ready=0 and send dual-event beats.
  - The first beat is accepted (count 0→2). The second is accepted because count=2 ≤ 2 (count→4). in_ready then drops to 0.
  - A third beat is held and not lost.
  - Raise out_ready: events drain in exact order, and in_ready returns once count≤2.
- Simultaneous push and pop at count=2 with a dual beat: count becomes 3, and the head advances correctly.
- Pointer wrap: stream 10 single CSR beats with out_ready toggling 1/0.
  - All 10 emerge in order with no duplicates or drops.
  - commit_cnt=10.
- Reset mid-drain: with 3 events buffered, pulse reset=0 for one cycle.
  - Next cycle: out_valid=0, commit_cnt=0, in_ready=1. No stale events are emitted afterwards.

Source files
------------

// File: rtl/csr_commit_sched.sv
// Splits each WB beat into CSR-write and exception events in FIFO order. They appear on out_* one cycle after acceptance and issue at most one per cycle.
// in_ready deasserts when fewer than two slots remain, and the head event holds steady while out_ready is low.
module csr_commit_sched #(
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_csr_wen,
  input  logic [31:0]   in_csr_waddr,
  input  logic [31:0]   in_csr_wdata,
  input  logic          in_exc_wen,
  input  logic [31:0]   in_mcause,
  input  logic [31:0]   in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [31:0]   out_data0,
  output logic [31:0]   out_data1,
  output logic [CW-1:0] commit_cnt,
  output logic          idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ROOM_LVL = (AW+1)'(DEPTH - 2);

  typedef struct packed {
    logic        kind;
    logic [31:0] data0;
    logic [31:0] data1;
  } ev_t;

  ev_t           mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic          accept;
  logic          push_csr;
  logic          push_exc;
  logic          pop;
  logic [1:0]    pushes;
  logic [AW-1:0] wptr_exc;
  ev_t           head;

  // Admission needs room for a full dual-event beat, judged from registered count only.
  assign in_ready  = reset && (count <= ROOM_LVL);
  assign accept    = in_valid && in_ready;
  assign push_csr  = accept && in_csr_wen;
  assign push_exc  = accept && in_exc_wen;
  assign pushes    = {1'b0, push_csr} + {1'b0, push_exc};
  assign wptr_exc  = push_csr ? wptr + AW'(1) : wptr;

  assign head      = mem[rptr];
  assign out_valid = reset && (count != '0);
  assign out_kind  = head.kind;
  assign out_data0 = head.data0;
  assign out_data1 = head.data1;
  assign pop       = out_valid && out_ready;

  assign idle      = (count == '0) && !in_valid;

  always_ff @(posedge clock) begin
    if (push_csr)
      mem[wptr] <= '{kind: 1'b0, data0: in_csr_waddr, data1: in_csr_wdata};
    if (push_exc)
      mem[wptr_exc] <= '{kind: 1'b1, data0: in_mcause, data1: in_pc};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      commit_cnt <= '0;
    end else begin
      wptr  <= wptr + AW'(pushes);
      count <= count + (AW+1)'(pushes) - (AW+1)'(pop);
      if (pop) begin
        rptr       <= rptr + AW'(1);
        commit_cnt <= commit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_csr_commit_sched.sv
// Directed bench for csr_commit_sched: single/dual beats, backpressure, wrap, reset mid-drain.
module tb_csr_commit_sched;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_csr_wen;
  logic [31:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc_wen;
  logic [31:0] in_mcause;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] commit_cnt;
  logic        idle;

  int errors = 0;
  int checks = 0;

  csr_commit_sched #(.DEPTH(4), .CW(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_csr_wen   (in_csr_wen),
    .in_csr_waddr (in_csr_waddr),
    .in_csr_wdata (in_csr_wdata),
    .in_exc_wen   (in_exc_wen),
    .in_mcause    (in_mcause),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kind     (out_kind),
    .out_data0    (out_data0),
    .out_data1    (out_data1),
    .commit_cnt   (commit_cnt),
    .idle         (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(input logic cw, input logic [31:0] a, input logic [31:0] d,
                      input logic ew, input logic [31:0] c, input logic [31:0] p);
    in_valid     = 1'b1;
    in_csr_wen   = cw;
    in_csr_waddr = a;
    in_csr_wdata = d;
    in_exc_wen   = ew;
    in_mcause    = c;
    in_pc        = p;
  endtask

  task automatic no_beat();
    in_valid   = 1'b0;
    in_csr_wen = 1'b0;
    in_exc_wen = 1'b0;
  endtask

  task automatic head(input string tag, input logic k, input logic [31:0] d0, input logic [31:0] d1);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_kind"}, {31'd0, out_kind}, {31'd0, k});
    chk({tag, "_d0"}, out_data0, d0);
    chk({tag, "_d1"}, out_data1, d1);
  endtask

  initial begin
    int sent;
    int rcv;
    reset = 1'b0;
    out_ready = 1'b0;
    in_csr_waddr = '0;
    in_csr_wdata = '0;
    in_mcause = '0;
    in_pc = '0;
    no_beat();

    // Reset state
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_commit_cnt", commit_cnt, 32'd0);
    reset = 1'b1;
    settle();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);

    // Single CSR write
    beat(1'b1, 32'h300, 32'h1800, 1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    settle();
    chk("busy_idle", {31'd0, idle}, 32'd0);
    tick();
    no_beat();
    settle();
    head("single", 1'b0, 32'h300, 32'h1800);
    chk("single_cnt_before", commit_cnt, 32'd0);
    tick();
    chk("single_drained", {31'd0, out_valid}, 32'd0);
    chk("single_cnt", commit_cnt, 32'd1);
    chk("single_idle", {31'd0, idle}, 32'd1);

    // Dual event: CSR write precedes exception
    beat(1'b1, 32'h341, 32'h8000_0010, 1'b1, 32'd11, 32'h8000_0010);
    tick();
    no_beat();
    settle();
    head("dual_a", 1'b0, 32'h341, 32'h8000_0010);
    tick();
    head("dual_b", 1'b1, 32'd11, 32'h8000_0010);
    tick();
    chk("dual_drained", {31'd0, out_valid}, 32'd0);
    chk("dual_cnt", commit_cnt, 32'd3);

    // Backpressure until full
    out_ready = 1'b0;
    beat(1'b1, 32'h100, 32'hA0, 1'b1, 32'h2, 32'hB0);
    tick();
    beat(1'b1, 32'h101, 32'hA1, 1'b1, 32'h3, 32'hB1);
    settle();
    chk("bp_ready_at2", {31'd0, in_ready}, 32'd1);
    tick();
    beat(1'b1, 32'h102, 32'hA2, 1'b1, 32'h4, 32'hB2);
    settle();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_ready_held", {31'd0, in_ready}, 32'd0);
    head("bp_stable1", 1'b0, 32'h100, 32'hA0);
    tick();
    head("bp_stable2", 1'b0, 32'h100, 32'hA0);
    out_ready = 1'b1;
    tick();
    head("drain_a_exc", 1'b1, 32'h2, 32'hB0);
    chk("drain_ready_at3", {31'd0, in_ready}, 32'd0);
    tick();
    head("drain_b_csr", 1'b0, 32'h101, 32'hA1);
    chk("drain_ready_at2", {31'd0, in_ready}, 32'd1);
    // Held beat C accepted together with a pop at count 2
    tick();
    no_beat();
    settle();
    head("pp_b_exc", 1'b1, 32'h3, 32'hB1);
    chk("pp_ready_at3", {31'd0, in_ready}, 32'd0);
    tick();
    head("pp_c_csr", 1'b0, 32'h102, 32'hA2);
    chk("pp_ready_at2", {31'd0, in_ready}, 32'd1);
    tick();
    head("pp_c_exc", 1'b1, 32'h4, 32'hB2);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_cnt", commit_cnt, 32'd9);

    // Pointer wrap: 10 singles with out_ready toggling
    sent = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent < 10) beat(1'b1, 32'h200 + 32'(sent), 32'(sent * 3 + 7), 1'b0, 32'h0, 32'h0);
      else no_beat();
      out_ready = cyc[0];
      settle();
      if (out_valid && out_ready) begin
        chk("wrap_kind", {31'd0, out_kind}, 32'd0);
        chk("wrap_d0", out_data0, 32'h200 + 32'(rcv));
        chk("wrap_d1", out_data1, 32'(rcv * 3 + 7));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    no_beat();
    chk("wrap_rcv", 32'(rcv), 32'd10);
    chk("wrap_cnt", commit_cnt, 32'd19);
    chk("wrap_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-drain with 3 buffered events
    out_ready = 1'b0;
    beat(1'b1, 32'h301, 32'h11, 1'b0, 32'h0, 32'h0);
    tick();
    beat(1'b1, 32'h302, 32'h22, 1'b0, 32'h0, 32'h0);
    tick();
    beat(1'b1, 32'h303, 32'h33, 1'b0, 32'h0, 32'h0);
    tick();
    no_beat();
    settle();
    head("mid_head", 1'b0, 32'h301, 32'h11);
    out_ready = 1'b1;
    reset = 1'b0;
    tick();
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    settle();
    chk("mid_post_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_post_cnt", commit_cnt, 32'd0);
    chk("mid_post_rdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    chk("no_stale_cnt", commit_cnt, 32'd0);
    beat(1'b1, 32'h7C0, 32'h55, 1'b0, 32'h0, 32'h0);
    tick();
    no_beat();
    settle();
    head("after_rst", 1'b0, 32'h7C0, 32'h55);
    tick();
    chk("after_rst_cnt", commit_cnt, 32'd1);
    chk("after_rst_idle", {31'd0, idle}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
